gol_grid_engine: RTL and testbench

//   Cell-array datapath downstream of the game-of-life control FSM. Consumes game_state,

---
 rtl/gol_grid_engine.sv | 153 +++++++++++++++
 tb/tb_gol_grid_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gol_grid_engine.sv
// Purpose  : toroidal ROWSxCOLS Conway grid; user edits in PROGRAM, one generation per tick in RUN.
// Latency  : tick expiry to grid update is N+1 cycles (N scan cycles + 1 commit cycle).
// Backpress: none; buttons are ignored while busy, and game_state=00 aborts and clears at once.
// Ports    : clka/rst_n (sync, active-low); game_state 00 IDLE/01 PROGRAM/10 RUN/11 PAUSE;
//            cell_idx/btn0/btn1 edit cursor and clear/set pulses; grid = current generation
//            (bits >= N stay 0); gen_count wraps; busy during scan/commit; gen_done pulses in
//            the commit cycle; extinct high while the committed grid is empty.
module gol_grid_engine #(
   parameter int ROWS     = 8,
   parameter int COLS     = 16,
   parameter int TICK_DIV = 1000000,
   parameter int GEN_W    = 16
) (
   input  logic             clka,
   input  logic             rst_n,
   input  logic [1:0]       game_state,
   input  logic [6:0]       cell_idx,
   input  logic             btn0,
   input  logic             btn1,
   output logic [127:0]     grid,
   output logic [GEN_W-1:0] gen_count,
   output logic             busy,
   output logic             gen_done,
   output logic             extinct
);
   localparam int            N         = ROWS * COLS;
   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [6:0]    SCAN_LAST = 7'(N - 1);

   typedef enum logic [2:0] {S_IDLE, S_EDIT, S_WAIT, S_SCAN, S_COMMIT} state_t;

   state_t           state_q;
   logic [127:0]     grid_q;
   logic [127:0]     next_q;
   logic [GEN_W-1:0] gen_q;
   logic [TW-1:0]    tick_q;
   logic [6:0]       scan_q;
   logic             busy_q;
   logic             gen_done_q;
   logic             extinct_q;

   logic [127:0]     grid_edit_d;
   logic [3:0]       nbr_cnt_d;
   logic             next_bit_d;
   int               scan_r;
   int               scan_c;

   function automatic logic cell_at(input logic [127:0] g, input int r, input int c);
      logic [6:0] ix;
      ix = 7'(r * COLS + c);
      return g[ix];
   endfunction

   // Edit result for the cursor cell; both buttons together toggle.
   always_comb begin
      grid_edit_d = grid_q;
      if (int'(cell_idx) < N) begin
         if (btn0 && btn1)
            grid_edit_d[cell_idx] = ~grid_q[cell_idx];
         else if (btn1)
            grid_edit_d[cell_idx] = 1'b1;
         else if (btn0)
            grid_edit_d[cell_idx] = 1'b0;
      end
   end

   // Live rule for the scanned cell; reads grid_q, which stays frozen for the whole scan.
   always_comb begin
      scan_r    = int'(scan_q) / COLS;
      scan_c    = int'(scan_q) % COLS;
      nbr_cnt_d = 4'd0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
               nbr_cnt_d = nbr_cnt_d + 4'(cell_at(grid_q, (scan_r + dr + ROWS) % ROWS,
                                                  (scan_c + dc + COLS) % COLS));
         end
      end
      next_bit_d = (nbr_cnt_d == 4'd3) ||
                   (cell_at(grid_q, scan_r, scan_c) && (nbr_cnt_d == 4'd2));
   end

   always_ff @(posedge clka) begin
      // game_state=00 behaves like reset: any scan in flight is dropped without gen_done.
      if (!rst_n || game_state == 2'b00) begin
         state_q    <= S_IDLE;
         grid_q     <= '0;
         next_q     <= '0;
         gen_q      <= '0;
         tick_q     <= '0;
         scan_q     <= '0;
         busy_q     <= 1'b0;
         gen_done_q <= 1'b0;
         extinct_q  <= 1'b1;
      end else begin
         gen_done_q <= 1'b0;
         busy_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tick_q  <= '0;
               state_q <= (game_state == 2'b01) ? S_EDIT : S_WAIT;
            end
            S_EDIT: begin
               grid_q    <= grid_edit_d;
               extinct_q <= (grid_edit_d == '0);
               if (game_state != 2'b01) begin
                  tick_q  <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (game_state == 2'b01) begin
                  state_q <= S_EDIT;
               end else if (game_state == 2'b10) begin
                  if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     scan_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_SCAN;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            S_SCAN: begin
               busy_q         <= 1'b1;
               next_q[scan_q] <= next_bit_d;
               if (scan_q == SCAN_LAST) begin
                  gen_done_q <= 1'b1;
                  state_q    <= S_COMMIT;
               end else begin
                  scan_q <= scan_q + 1'b1;
               end
            end
            S_COMMIT: begin
               grid_q    <= next_q;
               gen_q     <= gen_q + 1'b1;
               extinct_q <= (next_q == '0);
               state_q   <= (game_state == 2'b01) ? S_EDIT : S_WAIT;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grid      = grid_q;
   assign gen_count = gen_q;
   assign busy      = busy_q;
   assign gen_done  = gen_done_q;
   assign extinct   = extinct_q;

endmodule

// File: tb/tb_gol_grid_engine.sv
// Purpose  : directed self-checking bench for gol_grid_engine (8x16 main instance, 8x8 for cursor range).
// Latency  : expects gen_done 1+TICK_DIV+N cycles after RUN from PROGRAM, then TICK_DIV+N+1 periodic.
// Backpress: none; every wait on gen_done is bounded by a cycle budget.
module tb_gol_grid_engine;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   gs;
   logic [6:0]   idx;
   logic         b0, b1;
   logic [127:0] grid, grid8;
   logic [15:0]  gen, gen8;
   logic         busy, busy8, gd, gd8, ext, ext8;

   int n_chk  = 0;
   int n_fail = 0;
   int gd_cnt = 0;
   int cyc;
   int base;

   always #5 clk = ~clk;

   gol_grid_engine #(.ROWS(8), .COLS(16), .TICK_DIV(4), .GEN_W(16)) dut (
      .clka(clk), .rst_n(rst_n), .game_state(gs), .cell_idx(idx), .btn0(b0), .btn1(b1),
      .grid(grid), .gen_count(gen), .busy(busy), .gen_done(gd), .extinct(ext));

   gol_grid_engine #(.ROWS(8), .COLS(8), .TICK_DIV(4), .GEN_W(16)) dut8 (
      .clka(clk), .rst_n(rst_n), .game_state(gs), .cell_idx(idx), .btn0(b0), .btn1(b1),
      .grid(grid8), .gen_count(gen8), .busy(busy8), .gen_done(gd8), .extinct(ext8));

   // gen_done is a one-cycle pulse, so sampling it at each posedge counts every pulse once.
   always @(posedge clk) if (gd) gd_cnt <= gd_cnt + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_gd(input int budget, output int c);
      c = 0;
      while (gd !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (gd !== 1'b1) chk("gen_done_timeout", {127'd0, gd}, 128'd1);
   endtask

   task automatic edit(input int i, input logic c0, input logic c1);
      idx = 7'(i);
      b0  = c0;
      b1  = c1;
      @(negedge clk);
      b0 = 1'b0;
      b1 = 1'b0;
   endtask

   task automatic restart_program();
      gs = 2'b00;
      tick(1);
      gs = 2'b01;
      tick(1);
   endtask

   function automatic logic [127:0] mask(input int a, input int b = -1, input int c = -1,
                                         input int d = -1, input int e = -1);
      logic [127:0] m;
      m = '0;
      if (a >= 0) m[a] = 1'b1;
      if (b >= 0) m[b] = 1'b1;
      if (c >= 0) m[c] = 1'b1;
      if (d >= 0) m[d] = 1'b1;
      if (e >= 0) m[e] = 1'b1;
      return m;
   endfunction

   initial begin
      // Reset wins over RUN and a held set button.
      rst_n = 1'b0; gs = 2'b10; idx = 7'd5; b0 = 1'b0; b1 = 1'b1;
      tick(2);
      chk("rst_grid", grid, '0);
      chk("rst_gen", {112'd0, gen}, '0);
      chk("rst_extinct", {127'd0, ext}, 128'd1);
      chk("rst_busy", {127'd0, busy}, '0);
      rst_n = 1'b1; gs = 2'b00; b1 = 1'b0;
      tick(3);
      chk("idle_grid", grid, '0);

      // Editing: set, clear, toggle, and an out-of-range cursor on the 8x8 instance.
      gs = 2'b01;
      tick(1);
      edit(17, 1'b0, 1'b1);
      edit(18, 1'b0, 1'b1);
      edit(19, 1'b0, 1'b1);
      edit(18, 1'b1, 1'b0);
      edit(20, 1'b1, 1'b1);
      edit(127, 1'b0, 1'b1);
      chk("edit_grid8", grid8, mask(17, 19, 20));
      chk("edit_grid", grid, mask(17, 19, 20, 127));
      chk("edit_extinct", {127'd0, ext}, '0);

      // Blinker: horizontal row 1 flips to vertical column 2 and back.
      restart_program();
      edit(17, 1'b0, 1'b1);
      edit(18, 1'b0, 1'b1);
      edit(19, 1'b0, 1'b1);
      gs = 2'b10;
      wait_gd(400, cyc);
      chk("blink_latency", cyc, 133);
      chk("blink_busy_commit", {127'd0, busy}, 128'd1);
      tick(1);
      chk("blink_gen1", grid, mask(2, 18, 34));
      chk("blink_cnt1", {112'd0, gen}, 128'd1);
      chk("blink_busy_wait", {127'd0, busy}, '0);
      wait_gd(400, cyc);
      chk("blink_period", cyc, 132);
      tick(1);
      chk("blink_gen2", grid, mask(17, 18, 19));
      chk("blink_cnt2", {112'd0, gen}, 128'd2);

      // Glider moves (+1 row, +1 col) every 4 generations; rows wrap through the bottom edge.
      restart_program();
      edit(1, 1'b0, 1'b1);
      edit(18, 1'b0, 1'b1);
      edit(32, 1'b0, 1'b1);
      edit(33, 1'b0, 1'b1);
      edit(34, 1'b0, 1'b1);
      gs = 2'b10;
      for (int g = 1; g <= 32; g++) begin
         wait_gd(400, cyc);
         tick(1);
         if (g == 4)  chk("glider_g4", grid, mask(18, 35, 49, 50, 51));
         if (g == 28) chk("glider_g28_wrap", grid, mask(120, 9, 23, 24, 25));
         if (g == 32) chk("glider_g32", grid, mask(9, 26, 40, 41, 42));
      end
      chk("glider_cnt", {112'd0, gen}, 128'd32);

      // Pause at scan cell 50: that generation still commits, then everything holds.
      restart_program();
      edit(17, 1'b0, 1'b1);
      edit(18, 1'b0, 1'b1);
      edit(19, 1'b0, 1'b1);
      gs = 2'b10;
      tick(55);
      chk("pause_busy_midscan", {127'd0, busy}, 128'd1);
      gs = 2'b11;
      wait_gd(200, cyc);
      tick(1);
      chk("pause_grid", grid, mask(2, 18, 34));
      chk("pause_cnt", {112'd0, gen}, 128'd1);
      base = gd_cnt;
      tick(1000);
      chk("pause_no_gen_done", gd_cnt - base, 0);
      chk("pause_busy", {127'd0, busy}, '0);
      gs = 2'b10;
      wait_gd(400, cyc);
      chk("resume_latency", cyc, 132);
      tick(1);
      chk("resume_grid", grid, mask(17, 18, 19));

      // Abort at scan cell 50: no commit, everything cleared.
      restart_program();
      edit(17, 1'b0, 1'b1);
      edit(18, 1'b0, 1'b1);
      edit(19, 1'b0, 1'b1);
      gs = 2'b10;
      base = gd_cnt;
      tick(55);
      gs = 2'b00;
      tick(1);
      chk("abort_grid", grid, '0);
      chk("abort_cnt", {112'd0, gen}, '0);
      chk("abort_extinct", {127'd0, ext}, 128'd1);
      chk("abort_busy", {127'd0, busy}, '0);
      tick(200);
      chk("abort_no_gen_done", gd_cnt - base, 0);

      // A lone cell dies in one generation.
      gs = 2'b01;
      tick(1);
      edit(40, 1'b0, 1'b1);
      chk("lone_extinct_pre", {127'd0, ext}, '0);
      gs = 2'b10;
      wait_gd(400, cyc);
      tick(1);
      chk("lone_grid", grid, '0);
      chk("lone_extinct", {127'd0, ext}, 128'd1);
      chk("lone_cnt", {112'd0, gen}, 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
